// File: rtl/tcam_pkg.sv
// tcam_pkg: shared widths, FSM states and TCAM command layout for the access arbiter
package tcam_pkg;
    localparam int KEY_W   = 28;
    localparam int RES_W   = 6;
    localparam int WDATA_W = 32;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    typedef struct packed {
        logic               csb;
        logic               web;
        logic [3:0]         wmask;
        logic [KEY_W-1:0]   addr;
        logic [WDATA_W-1:0] wdata;
    } tcam_cmd_t;
endpackage

// File: rtl/tcam_arb_prio.sv
// tcam_arb_prio: search-first priority selector with a saturating update starvation guard
module tcam_arb_prio #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic srch_valid_i,
    input  logic upd_valid_i,
    output logic grant_srch_o,
    output logic grant_upd_o
);
    logic [3:0] starve_q;
    logic       starved;

    assign starved      = starve_q == 4'(STARVE_MAX);
    assign grant_upd_o  = en_i && upd_valid_i && (!srch_valid_i || starved);
    assign grant_srch_o = en_i && srch_valid_i && !grant_upd_o;

    // count update losses only when the arbiter is actually choosing; clear on an update win
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            starve_q <= '0;
        else if (grant_upd_o)
            starve_q <= '0;
        else if (en_i && upd_valid_i && !starved)
            starve_q <= starve_q + 4'd1;
    end
endmodule

// File: rtl/tcam_access_arb.sv
// tcam_access_arb: shares one TCAM between a search port and an update port, one command at a time
module tcam_access_arb #(
    parameter int RD_LAT     = 2,
    parameter int STARVE_MAX = 4,
    parameter int KEY_W      = tcam_pkg::KEY_W,
    parameter int RES_W      = tcam_pkg::RES_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             srch_valid_i,
    output logic             srch_ready_o,
    input  logic [KEY_W-1:0] srch_key_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [RES_W-1:0] rsp_data_o,
    input  logic             upd_valid_i,
    output logic             upd_ready_o,
    input  logic [KEY_W-1:0] upd_addr_i,
    input  logic [31:0]      upd_wdata_i,
    input  logic [3:0]       upd_wmask_i,
    output logic             upd_done_o,
    output logic             tcam_csb_o,
    output logic             tcam_web_o,
    output logic [3:0]       tcam_wmask_o,
    output logic [KEY_W-1:0] tcam_addr_o,
    output logic [31:0]      tcam_wdata_o,
    input  logic [RES_W-1:0] tcam_rdata_i,
    output logic             busy_o
);
    import tcam_pkg::*;

    state_t           state_q;
    tcam_cmd_t        cmd_q;
    logic [2:0]       lat_q;
    logic             rsp_valid_q, upd_done_q, busy_q;
    logic [RES_W-1:0] rsp_data_q;
    logic             arb_en, grant_srch, grant_upd, lat_done;

    assign arb_en   = state_q == IDLE && !rst_i;
    assign lat_done = lat_q == 3'(RD_LAT - 1);

    tcam_arb_prio #(.STARVE_MAX(STARVE_MAX)) u_prio (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .en_i        (arb_en),
        .srch_valid_i(srch_valid_i),
        .upd_valid_i (upd_valid_i),
        .grant_srch_o(grant_srch),
        .grant_upd_o (grant_upd)
    );

    assign srch_ready_o = grant_srch;
    assign upd_ready_o  = grant_upd;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_data_o   = rsp_data_q;
    assign upd_done_o   = upd_done_q;
    assign busy_o       = busy_q;
    assign tcam_csb_o   = cmd_q.csb;
    assign tcam_web_o   = cmd_q.web;
    assign tcam_wmask_o = cmd_q.wmask;
    assign tcam_addr_o  = cmd_q.addr;
    assign tcam_wdata_o = cmd_q.wdata;

    // command sequencer: accept, issue one cycle, wait out read latency, hold result until taken
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cmd_q       <= '{csb: 1'b1, web: 1'b1, wmask: '0, addr: '0, wdata: '0};
            lat_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            upd_done_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            upd_done_q <= 1'b0;
            case (state_q)
                IDLE: if (grant_srch || grant_upd) begin
                    state_q     <= ISSUE;
                    busy_q      <= 1'b1;
                    lat_q       <= '0;
                    upd_done_q  <= grant_upd;
                    cmd_q.csb   <= 1'b0;
                    cmd_q.web   <= !grant_upd;
                    cmd_q.wmask <= grant_upd ? upd_wmask_i : 4'h0;
                    cmd_q.addr  <= grant_upd ? upd_addr_i : srch_key_i;
                    cmd_q.wdata <= grant_upd ? upd_wdata_i : cmd_q.wdata;
                end
                ISSUE, WAIT: begin
                    cmd_q.csb <= 1'b1;
                    cmd_q.web <= 1'b1;
                    if (state_q == ISSUE && !cmd_q.web) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (lat_done) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= tcam_rdata_i;
                    end else begin
                        state_q <= WAIT;
                        lat_q   <= lat_q + 3'd1;
                    end
                end
                RESP: if (rsp_ready_i) begin
                    state_q     <= IDLE;
                    rsp_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // requesters must keep the payload stable while valid waits for ready
    a_srch_hold: assert property (@(posedge clk_i) disable iff (rst_i)
        srch_valid_i && !srch_ready_o |=> !srch_valid_i || $stable(srch_key_i));
    a_upd_hold: assert property (@(posedge clk_i) disable iff (rst_i)
        upd_valid_i && !upd_ready_o |=> !upd_valid_i || $stable({upd_addr_i, upd_wdata_i, upd_wmask_i}));
endmodule
